// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the data-RAM arbiter.
package ram_arb_pkg;

  localparam int unsigned N_REQ = 2;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arb_state_e;

  // True when the access size does not match the alignment of the byte address.
  function automatic logic misaligned(input logic [1:0] memtype, input logic [1:0] addr_lo);
    case (memtype)
      MEM_BYTE: return 1'b0;
      MEM_HALF: return addr_lo[0];
      MEM_WORD: return (addr_lo != 2'b00);
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester and RAM-side signals of the data-RAM arbiter.
// master: requesters plus RAM model; slave: the arbiter.
interface ram_arbiter_if #(
  parameter int unsigned WIDTH = 32
);
  import ram_arb_pkg::*;

  logic [N_REQ-1:0] req_i;
  logic [N_REQ-1:0] we_i;
  logic [1:0]       memtype0_i;
  logic [1:0]       memtype1_i;
  logic             memsign0_i;
  logic             memsign1_i;
  logic [WIDTH-1:0] addr0_i;
  logic [WIDTH-1:0] addr1_i;
  logic [WIDTH-1:0] wdata0_i;
  logic [WIDTH-1:0] wdata1_i;
  logic [N_REQ-1:0] gnt_o;
  logic [N_REQ-1:0] rvalid_o;
  logic [WIDTH-1:0] rdata_o;
  logic             err_o;
  logic             mem_we_o;
  logic [1:0]       mem_memtype_o;
  logic             mem_memsign_o;
  logic [WIDTH-1:0] mem_a_o;
  logic [WIDTH-1:0] mem_wd_o;
  logic [WIDTH-1:0] mem_rd_i;

  modport master (
    output req_i, we_i, memtype0_i, memtype1_i, memsign0_i, memsign1_i,
           addr0_i, addr1_i, wdata0_i, wdata1_i, mem_rd_i,
    input  gnt_o, rvalid_o, rdata_o, err_o, mem_we_o, mem_memtype_o,
           mem_memsign_o, mem_a_o, mem_wd_o
  );

  modport slave (
    input  req_i, we_i, memtype0_i, memtype1_i, memsign0_i, memsign1_i,
           addr0_i, addr1_i, wdata0_i, wdata1_i, mem_rd_i,
    output gnt_o, rvalid_o, rdata_o, err_o, mem_we_o, mem_memtype_o,
           mem_memsign_o, mem_a_o, mem_wd_o
  );

endinterface

// File: rtl/ram_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin pick; last = index granted previously.
module rr_arbiter2
  import ram_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic             last,
  output logic [N_REQ-1:0] gnt
);

  // Contention goes to the requester not granted last time; otherwise pass through.
  always_comb begin
    gnt = '0;
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter and access sequencer for the data RAM.
// Optional build macro: RAM_ARB_MISALIGN_EN enables misaligned-access errors.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic          clk_i,
  input logic          rst_ni,
  ram_arbiter_if.slave bus
);

  arb_state_e       state_q, state_d;
  logic             last_q, last_d;
  logic             we_q, we_d;
  logic [1:0]       memtype_q, memtype_d;
  logic             memsign_q, memsign_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             mis_q, mis_d;
  logic             mem_we_q, mem_we_d;
  logic [N_REQ-1:0] rvalid_q, rvalid_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;

  logic [N_REQ-1:0] pick;
  logic             win;
  logic             sel_we;
  logic [1:0]       sel_type;
  logic             sel_sign;
  logic [WIDTH-1:0] sel_addr;
  logic [WIDTH-1:0] sel_wdata;
  logic             sel_mis;

  rr_arbiter2 u_rr (
    .req  (bus.req_i),
    .last (last_q),
    .gnt  (pick)
  );

  // Grant is only offered when no access is on the RAM port.
  always_comb begin
    bus.gnt_o = '0;
    if ((state_q == IDLE) || (state_q == RESP)) begin
      bus.gnt_o = pick;
    end
  end

  // Payload of whichever requester the arbiter picked.
  always_comb begin
    win       = pick[1];
    sel_we    = win ? bus.we_i[1]    : bus.we_i[0];
    sel_type  = win ? bus.memtype1_i : bus.memtype0_i;
    sel_sign  = win ? bus.memsign1_i : bus.memsign0_i;
    sel_addr  = win ? bus.addr1_i    : bus.addr0_i;
    sel_wdata = win ? bus.wdata1_i   : bus.wdata0_i;
`ifdef RAM_ARB_MISALIGN_EN
    sel_mis   = misaligned(sel_type, sel_addr[1:0]);
`else
    sel_mis   = 1'b0;
`endif
  end

  // Next-state logic; the grant pointer doubles as response owner because no
  // grant can occur in ACCESS and rvalid is registered at the ACCESS->RESP edge.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    we_d      = we_q;
    memtype_d = memtype_q;
    memsign_d = memsign_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mis_d     = mis_q;
    mem_we_d  = 1'b0;
    rvalid_d  = '0;
    rdata_d   = rdata_q;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (|bus.req_i) state_d = ACCESS;
      end
      ACCESS: begin
        state_d          = RESP;
        rvalid_d[last_q] = 1'b1;
        rdata_d          = (we_q || mis_q) ? '0 : bus.mem_rd_i;
        err_d            = mis_q;
      end
      RESP: begin
        state_d = (|bus.req_i) ? ACCESS : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (|bus.gnt_o) begin
      last_d    = win;
      we_d      = sel_we;
      memtype_d = sel_type;
      memsign_d = sel_sign;
      addr_d    = sel_addr;
      wdata_d   = sel_wdata;
      mis_d     = sel_mis;
      mem_we_d  = sel_we & ~sel_mis;
    end
  end

  // State and registered outputs; async reset also kills an in-flight store.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      we_q      <= 1'b0;
      memtype_q <= MEM_WORD;
      memsign_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      mis_q     <= 1'b0;
      mem_we_q  <= 1'b0;
      rvalid_q  <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      we_q      <= we_d;
      memtype_q <= memtype_d;
      memsign_q <= memsign_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      mis_q     <= mis_d;
      mem_we_q  <= mem_we_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign bus.mem_we_o      = mem_we_q;
  assign bus.mem_memtype_o = memtype_q;
  assign bus.mem_memsign_o = memsign_q;
  assign bus.mem_a_o       = addr_q;
  assign bus.mem_wd_o      = wdata_q;
  assign bus.rvalid_o      = rvalid_q;
  assign bus.rdata_o       = rdata_q;
  assign bus.err_o         = err_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a word-indexed RAM model.
module tb_ram_arbiter;

  logic clk = 1'b0;
  logic rst_ni = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] ram [0:63];

  ram_arbiter_if #(.WIDTH(32)) bus ();

  ram_arbiter #(.WIDTH(32)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_rd_i = ram[bus.mem_a_o[7:2]];

  always @(posedge clk) begin
    if (bus.mem_we_o) ram[bus.mem_a_o[7:2]] <= bus.mem_wd_o;
  end

  task automatic idle_inputs();
    bus.req_i = 2'b00; bus.we_i = 2'b00;
    bus.memtype0_i = 2'b10; bus.memtype1_i = 2'b10;
    bus.memsign0_i = 1'b0; bus.memsign1_i = 1'b0;
    bus.addr0_i = '0; bus.addr1_i = '0; bus.wdata0_i = '0; bus.wdata1_i = '0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst_ni = 1'b0;
    @(negedge clk); #1;
    checks++; if (bus.gnt_o !== 2'b00) begin errors++; $display("FAIL rst_gnt got %b exp 00", bus.gnt_o); end
    checks++; if (bus.rvalid_o !== 2'b00) begin errors++; $display("FAIL rst_rvalid got %b exp 00", bus.rvalid_o); end
    checks++; if (bus.rdata_o !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", bus.rdata_o); end
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", bus.err_o); end
    checks++; if (bus.mem_we_o !== 1'b0) begin errors++; $display("FAIL rst_we got %b exp 0", bus.mem_we_o); end
    checks++; if (bus.mem_a_o !== 32'h0) begin errors++; $display("FAIL rst_a got %h exp 0", bus.mem_a_o); end
    checks++; if (bus.mem_wd_o !== 32'h0) begin errors++; $display("FAIL rst_wd got %h exp 0", bus.mem_wd_o); end
    checks++; if (bus.mem_memtype_o !== 2'b10) begin errors++; $display("FAIL rst_type got %b exp 10", bus.mem_memtype_o); end
    checks++; if (bus.mem_memsign_o !== 1'b0) begin errors++; $display("FAIL rst_sign got %b exp 0", bus.mem_memsign_o); end
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_store_load();
    bus.req_i = 2'b01; bus.we_i = 2'b01; bus.addr0_i = 32'h10; bus.wdata0_i = 32'hDEADBEEF;
    #1;
    checks++; if (bus.gnt_o !== 2'b01) begin errors++; $display("FAIL sl_gnt_st got %b exp 01", bus.gnt_o); end
    @(negedge clk);
    bus.req_i = 2'b00; #1;
    checks++; if (bus.mem_we_o !== 1'b1) begin errors++; $display("FAIL sl_we got %b exp 1", bus.mem_we_o); end
    checks++; if (bus.mem_a_o !== 32'h10) begin errors++; $display("FAIL sl_a got %h exp 10", bus.mem_a_o); end
    checks++; if (bus.mem_wd_o !== 32'hDEADBEEF) begin errors++; $display("FAIL sl_wd got %h exp deadbeef", bus.mem_wd_o); end
    checks++; if (bus.gnt_o !== 2'b00) begin errors++; $display("FAIL sl_gnt_acc got %b exp 00", bus.gnt_o); end
    @(negedge clk);
    bus.req_i = 2'b01; bus.we_i = 2'b00; #1;
    checks++; if (bus.rvalid_o !== 2'b01) begin errors++; $display("FAIL sl_rv_st got %b exp 01", bus.rvalid_o); end
    checks++; if (bus.rdata_o !== 32'h0) begin errors++; $display("FAIL sl_rd_st got %h exp 0", bus.rdata_o); end
    checks++; if (bus.mem_we_o !== 1'b0) begin errors++; $display("FAIL sl_we_resp got %b exp 0", bus.mem_we_o); end
    checks++; if (bus.gnt_o !== 2'b01) begin errors++; $display("FAIL sl_gnt_ld got %b exp 01", bus.gnt_o); end
    @(negedge clk);
    bus.req_i = 2'b00; #1;
    checks++; if (bus.mem_we_o !== 1'b0) begin errors++; $display("FAIL sl_we_ld got %b exp 0", bus.mem_we_o); end
    @(negedge clk); #1;
    checks++; if (bus.rvalid_o !== 2'b01) begin errors++; $display("FAIL sl_rv_ld got %b exp 01", bus.rvalid_o); end
    checks++; if (bus.rdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL sl_rd_ld got %h exp deadbeef", bus.rdata_o); end
    @(negedge clk); #1;
    checks++; if (bus.rvalid_o !== 2'b00) begin errors++; $display("FAIL sl_rv_idle got %b exp 00", bus.rvalid_o); end
    @(negedge clk);
  endtask

  task automatic test_contention();
    logic [1:0]  exp_gnt;
    logic [1:0]  exp_rv;
    logic [31:0] exp_rd;
    do_reset();
    bus.req_i = 2'b11; bus.we_i = 2'b00; bus.addr0_i = 32'h20; bus.addr1_i = 32'h24;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      exp_gnt = (k % 2 != 0) ? 2'b00 : ((k % 4 == 0) ? 2'b01 : 2'b10);
      exp_rv  = (k < 2 || k % 2 != 0) ? 2'b00 : (((k - 2) % 4 == 0) ? 2'b01 : 2'b10);
      checks++; if (bus.gnt_o !== exp_gnt) begin errors++; $display("FAIL ct_gnt k=%0d got %b exp %b", k, bus.gnt_o, exp_gnt); end
      checks++; if (bus.rvalid_o !== exp_rv) begin errors++; $display("FAIL ct_rv k=%0d got %b exp %b", k, bus.rvalid_o, exp_rv); end
      if (exp_rv != 2'b00) begin
        exp_rd = (exp_rv == 2'b01) ? 32'hA500_0008 : 32'hA500_0009;
        checks++; if (bus.rdata_o !== exp_rd) begin errors++; $display("FAIL ct_rd k=%0d got %h exp %h", k, bus.rdata_o, exp_rd); end
      end
    end
    @(negedge clk);
    bus.req_i = 2'b00; #1;
    checks++; if (bus.rvalid_o !== 2'b10) begin errors++; $display("FAIL ct_rv_last got %b exp 10", bus.rvalid_o); end
    checks++; if (bus.rdata_o !== 32'hA500_0009) begin errors++; $display("FAIL ct_rd_last got %h exp a5000009", bus.rdata_o); end
    checks++; if (bus.gnt_o !== 2'b00) begin errors++; $display("FAIL ct_gnt_last got %b exp 00", bus.gnt_o); end
    @(negedge clk);
  endtask

  task automatic test_resp_overlap();
    bus.req_i = 2'b10; bus.we_i = 2'b00; bus.addr1_i = 32'h28; #1;
    checks++; if (bus.gnt_o !== 2'b10) begin errors++; $display("FAIL ov_gnt1 got %b exp 10", bus.gnt_o); end
    @(negedge clk);
    bus.req_i = 2'b00;
    @(negedge clk);
    bus.req_i = 2'b01; bus.addr0_i = 32'h2C; #1;
    checks++; if (bus.rvalid_o !== 2'b10) begin errors++; $display("FAIL ov_rv1 got %b exp 10", bus.rvalid_o); end
    checks++; if (bus.gnt_o !== 2'b01) begin errors++; $display("FAIL ov_gnt0 got %b exp 01", bus.gnt_o); end
    checks++; if (bus.rdata_o !== 32'hA500_000A) begin errors++; $display("FAIL ov_rd1 got %h exp a500000a", bus.rdata_o); end
    @(negedge clk);
    bus.req_i = 2'b00;
    @(negedge clk); #1;
    checks++; if (bus.rvalid_o !== 2'b01) begin errors++; $display("FAIL ov_rv0 got %b exp 01", bus.rvalid_o); end
    checks++; if (bus.rdata_o !== 32'hA500_000B) begin errors++; $display("FAIL ov_rd0 got %h exp a500000b", bus.rdata_o); end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    bus.req_i = 2'b01; bus.we_i = 2'b01; bus.addr0_i = 32'h30; bus.wdata0_i = 32'hCAFEF00D; #1;
    checks++; if (bus.gnt_o !== 2'b01) begin errors++; $display("FAIL ab_gnt got %b exp 01", bus.gnt_o); end
    @(negedge clk);
    bus.req_i = 2'b00; #1;
    checks++; if (bus.mem_we_o !== 1'b1) begin errors++; $display("FAIL ab_we_pre got %b exp 1", bus.mem_we_o); end
    rst_ni = 1'b0; #1;
    checks++; if (bus.mem_we_o !== 1'b0) begin errors++; $display("FAIL ab_we_rst got %b exp 0", bus.mem_we_o); end
    @(negedge clk);
    rst_ni = 1'b1;
    bus.req_i = 2'b01; bus.we_i = 2'b00; #1;
    checks++; if (bus.rvalid_o !== 2'b00) begin errors++; $display("FAIL ab_rv_drop got %b exp 00", bus.rvalid_o); end
    checks++; if (bus.gnt_o !== 2'b01) begin errors++; $display("FAIL ab_gnt_ld got %b exp 01", bus.gnt_o); end
    @(negedge clk);
    bus.req_i = 2'b00;
    @(negedge clk); #1;
    checks++; if (bus.rvalid_o !== 2'b01) begin errors++; $display("FAIL ab_rv_ld got %b exp 01", bus.rvalid_o); end
    checks++; if (bus.rdata_o !== 32'hA500_000C) begin errors++; $display("FAIL ab_rd_old got %h exp a500000c", bus.rdata_o); end
    @(negedge clk);
  endtask

  task automatic test_misalign();
    logic        exp_we;
    logic        exp_err;
    logic [31:0] exp_ld;
`ifdef RAM_ARB_MISALIGN_EN
    exp_we = 1'b0; exp_err = 1'b1; exp_ld = 32'hDEADBEEF;
`else
    exp_we = 1'b1; exp_err = 1'b0; exp_ld = 32'h12345678;
`endif
    bus.req_i = 2'b01; bus.we_i = 2'b01; bus.memtype0_i = 2'b10;
    bus.addr0_i = 32'h13; bus.wdata0_i = 32'h12345678; #1;
    checks++; if (bus.gnt_o !== 2'b01) begin errors++; $display("FAIL ma_gnt got %b exp 01", bus.gnt_o); end
    @(negedge clk);
    bus.req_i = 2'b00; #1;
    checks++; if (bus.mem_we_o !== exp_we) begin errors++; $display("FAIL ma_we got %b exp %b", bus.mem_we_o, exp_we); end
    @(negedge clk);
    bus.req_i = 2'b01; bus.we_i = 2'b00; bus.addr0_i = 32'h10; #1;
    checks++; if (bus.rvalid_o !== 2'b01) begin errors++; $display("FAIL ma_rv got %b exp 01", bus.rvalid_o); end
    checks++; if (bus.err_o !== exp_err) begin errors++; $display("FAIL ma_err got %b exp %b", bus.err_o, exp_err); end
    checks++; if (bus.rdata_o !== 32'h0) begin errors++; $display("FAIL ma_rd got %h exp 0", bus.rdata_o); end
    @(negedge clk);
    bus.req_i = 2'b00;
    @(negedge clk); #1;
    checks++; if (bus.rvalid_o !== 2'b01) begin errors++; $display("FAIL ma_rv_ld got %b exp 01", bus.rvalid_o); end
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL ma_err_ld got %b exp 0", bus.err_o); end
    checks++; if (bus.rdata_o !== exp_ld) begin errors++; $display("FAIL ma_rd_ld got %h exp %h", bus.rdata_o, exp_ld); end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 32'hA500_0000 + i;
    idle_inputs();
    test_reset();
    test_store_load();
    test_contention();
    idle_inputs();
    test_resp_overlap();
    idle_inputs();
    test_reset_abort();
    idle_inputs();
    test_misalign();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter and access sequencer for the data RAM. It shares the single RAM port between requester 0 (CPU load/store unit) and requester 1 (program loader/debug port). It uses round-robin priority and a req/gnt/rvalid handshake. It drives the RAM's write-enable, address, write-data, memtype and memsign inputs, and returns load data to the granted requester.

## Interface
- `WIDTH`, 32, data and address width.
- `clk_i` input 1: clock; all state changes on its rising edge.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `req_i` input [1:0]: access request, one bit per requester.
- `we_i` input [1:0]: per-requester store (1) or load (0).
- `memtype0_i`, `memtype1_i` input 2 each: access size; 00 byte, 01 half, 10 word.
- `memsign0_i`, `memsign1_i` input 1 each: load sign-extension.
- `addr0_i`, `addr1_i` input WIDTH each: byte address.
- `wdata0_i`, `wdata1_i` input WIDTH each: store data.
- `gnt_o` output [1:0]: one-hot grant; request captured this cycle.
- `rvalid_o` output [1:0]: one-hot completion pulse for the granted requester.
- `rdata_o` output WIDTH: load data; valid while `rvalid_o` is nonzero.
- `err_o` output 1: misaligned-access error, qualified by `rvalid_o`.
- `mem_we_o` output 1: RAM write enable.
- `mem_memtype_o` output 2, `mem_memsign_o` output 1: to RAM.
- `mem_a_o`, `mem_wd_o` output WIDTH: to RAM.
- `mem_rd_i` input WIDTH: RAM read data. It is combinational from `mem_a_o`. Stores commit on the clock edge.

## Operation
- FSM states:
  - IDLE: no transaction outstanding.
  - ACCESS: captured request is presented to the RAM.
  - RESP: completion is reported.
- Transitions:
  - IDLE→ACCESS when any `req_i` bit is set.
  - ACCESS→RESP unconditionally.
  - RESP→ACCESS if any request is pending at that point; otherwise RESP→IDLE.
- Grants:
  - `gnt_o` is combinational and is asserted only in IDLE or RESP.
  - When it is asserted, the winner's `we`, memtype, memsign, addr and wdata are registered.
- Arbitration:
  - A single requester always wins.
  - If both request, the bit not granted last time wins.
  - The last-grant pointer updates on every grant.
- ACCESS state:
  - Mem outputs are driven from the captured registers.
  - `mem_we_o` equals the captured `we`.
  - `mem_rd_i` is registered into the read-data register.
- RESP state:
  - `rvalid_o[owner]` is 1 for exactly one cycle.
  - `rdata_o` is the registered read data. For stores it is 0.
- Mem outputs outside ACCESS: `mem_we_o`=0, other mem outputs hold the last captured values.
- Requesters must hold `req` and payload stable until granted. A request dropped before grant is simply not served.

## Timing
- Grant in cycle N, then RAM access in cycle N+1, then `rvalid_o` in N+2.
- Store commits at the end of N+1.
- Sustained throughput: one access per 2 cycles (grant overlaps RESP).
- Reset values:
  - FSM in IDLE.
  - `gnt_o`=0, `rvalid_o`=0, `rdata_o`=0, `err_o`=0, `mem_we_o`=0.
  - `mem_a_o`=0, `mem_wd_o`=0, `mem_memtype_o`=10, `mem_memsign_o`=0.
  - Last-grant pointer = 1, so requester 0 wins the first contention.
- Reset during ACCESS aborts the store: `mem_we_o` falls asynchronously and no write commits at the next edge. The in-flight response is dropped.
- Simultaneous `rvalid_o` to one requester and `gnt_o` to the other in RESP is legal and required.

## Configuration
- `RAM_ARB_MISALIGN_EN` defined:
  - Misalignment is checked at grant. Halfword with addr[0]=1, or word with addr[1:0]≠00, is misaligned.
  - A misaligned access still takes ACCESS but with `mem_we_o`=0.
  - In RESP it returns `err_o`=1 and `rdata_o`=0.
- `RAM_ARB_MISALIGN_EN` undefined:
  - No check; all accesses pass through.
  - `err_o` is tied 0.
- The port list is identical in both builds.

## Structure
- Package `ram_arb_pkg` holds:
  - memtype constants `MEM_BYTE`/`MEM_HALF`/`MEM_WORD`.
  - FSM state enum `arb_state_e` (IDLE, ACCESS, RESP).
  - Requester count `N_REQ`=2.
- Sub-module `rr_arbiter2`: combinational two-way round-robin pick. Inputs: `req` and the last-grant pointer. Output: one-hot grant. The pointer register stays in `ram_arbiter`.

## Test plan
- Reset, then requester 0 stores word 0xDEADBEEF at 0x10 and then loads 0x10. Expected: `gnt_o`=01, `mem_we_o`=1 in the cycle after grant, and the load `rvalid_o`=01 two cycles after its grant with `rdata_o`=0xDEADBEEF.
- Both requesters load continuously. Expected: grants alternate 01,10,01,…; the first contended grant goes to 0; one completion every 2 cycles.
- Requester 1 loads while requester 0 requests during RESP. Expected: `rvalid_o`=10 and `gnt_o`=01 in the same cycle.
- Requester 0 stores, then `rst_ni` is asserted mid-ACCESS. Expected: `mem_we_o` drops immediately, and a later load of that address returns its old contents.
- With `RAM_ARB_MISALIGN_EN`, word store at 0x13. Expected: `mem_we_o` stays 0, and `err_o`=1 with `rvalid_o`.
- Without the macro, the same word store at 0x13. Expected: write is performed and `err_o`=0.
